seq_pattern_detector: RTL and testbench

Parametrised serial pattern detector: a runtime-loadable bit pattern of 1..W bits is matched against a serial input stream qualified by a valid strobe. It supports overlapping and non-overlapping match modes and a saturating match counter. It is the general replacement for fixed-pattern FSM detectors. It sits behind switch/key glue logic, with `match` driving an indicator LED and `progress` driving the state LEDs.

---
 rtl/seq_pattern_detector.sv | 70 +++++++
 tb/tb_seq_pattern_detector.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: runtime-loadable 1..W bit serial pattern matcher with overlap control.
// Define SEQDET_MATCH_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module seq_pattern_detector #(
  parameter int W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter logic [W-1:0] RESET_PAT = W'(8'b0000_1101),
  parameter int RESET_LEN = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [W-1:0]     pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             overlap,
  input  logic             w_valid,
  input  logic             w,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN_W-1:0] progress
);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'((RESET_LEN > W) ? W : RESET_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(W);
  logic [W-1:0]     pat_q, hist_q, hist_d, mask;
  logic [LEN_W-1:0] len_q, fill_q, fill_d;
  logic             match_q, hit;
  function automatic logic [LEN_W-1:0] clamp(input logic [LEN_W-1:0] l);
    return (int'(l) > W) ? LEN_MAX : l;
  endfunction
  always_comb begin
    hist_d = {hist_q[W-2:0], w};
    fill_d = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    mask   = (W'(1) << len_q) - W'(1);
    hit    = (len_q != '0) && (fill_d >= len_q) && (((hist_d ^ pat_q) & mask) == '0);
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pat_q   <= RESET_PAT;
      len_q   <= RST_LEN;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else if (load) begin
      pat_q   <= pat_in;
      len_q   <= clamp(len_in);
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else if (w_valid) begin
      hist_q  <= hist_d;
      match_q <= hit;
      fill_q  <= (hit && !overlap) ? '0 : fill_d;
    end else begin
      match_q <= 1'b0;
    end
  end
`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else if (load) cnt_q <= '0;
    else if (w_valid && hit && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
  end
  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif
  assign match    = match_q;
  assign progress = fill_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed streams; driver queues expected match events, negedge monitor checks them.
module tb_seq_pattern_detector;
  logic       clk = 1'b0, resetn = 1'b0, load = 1'b0, ov = 1'b1, w_valid = 1'b0, w = 1'b0;
  logic [7:0] pat_in = '0;
  logic [3:0] len_in = '0;
  logic       match, match2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  logic [3:0] prog, prog2;
  typedef struct { int prog; int c8; int c2; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, m_fill = 0, m_cnt = 0;

  seq_pattern_detector dut (
    .clock(clk), .resetn(resetn), .load(load), .pat_in(pat_in), .len_in(len_in), .overlap(ov),
    .w_valid(w_valid), .w(w), .match(match), .match_count(cnt), .progress(prog));
  seq_pattern_detector #(.CNT_W(2)) dut2 (
    .clock(clk), .resetn(resetn), .load(load), .pat_in(pat_in), .len_in(len_in), .overlap(ov),
    .w_valid(w_valid), .w(w), .match(match2), .match_count(cnt2), .progress(prog2));

  always #5 clk = ~clk;

  function automatic int ec(input int c, input int mx);
`ifdef SEQDET_MATCH_COUNT_EN
    return (c > mx) ? mx : c;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (match) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_match: got match=1 expected 0 at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("match_progress", prog, e.prog);
        chk("match_count", cnt, e.c8);
        chk("match_count_w2", cnt2, e.c2);
        chk("match2", match2, 1);
        chk("progress2", prog2, e.prog);
      end
    end
  end

  task automatic send(input string bits, input string hits, input int gap);
    for (int i = 0; i < bits.len(); i++) begin
      byte b, h;
      b = bits[i];
      h = hits[i];
      w_valid = 1'b1;
      w = (b == "1");
      @(posedge clk);
      #1;
      w_valid = 1'b0;
      m_fill = (m_fill < 8) ? m_fill + 1 : 8;
      if (h == "1") begin
        m_cnt++;
        if (!ov) m_fill = 0;
        q.push_back('{m_fill, ec(m_cnt, 255), ec(m_cnt, 3)});
      end
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic ld(input logic [7:0] p, input logic [3:0] l, input logic wv, input logic wb);
    load = 1'b1;
    pat_in = p;
    len_in = l;
    w_valid = wv;
    w = wb;
    @(posedge clk);
    #1;
    load = 1'b0;
    w_valid = 1'b0;
    m_fill = 0;
    m_cnt = 0;
  endtask

  task automatic endchk(input string n, input int exp_prog);
    @(negedge clk);
    #1;
    chk({n, "_missed"}, q.size(), 0);
    q.delete();
    chk({n, "_progress"}, prog, exp_prog);
    chk({n, "_count"}, cnt, ec(m_cnt, 255));
    chk({n, "_count_w2"}, cnt2, ec(m_cnt, 3));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_match", match, 0);
    chk("reset_count", cnt, 0);
    chk("reset_progress", prog, 0);
    resetn = 1'b1;
    ov = 1'b1;
    send("1101101", "0001001", 0);
    endchk("default_ov", 7);
    ld(8'b1111, 4'd4, 1'b0, 1'b0);
    send("1111111", "0001111", 0);
    endchk("ones_ov", 7);
    ov = 1'b0;
    ld(8'b1111, 4'd4, 1'b0, 1'b0);
    send("1111111", "0001000", 0);
    endchk("ones_nov7", 3);
    send("1", "1", 0);
    endchk("ones_nov8", 0);
    ov = 1'b1;
    ld(8'b101, 4'd3, 1'b0, 1'b0);
    send("10101", "00101", 0);
    endchk("p101_ov", 5);
    ld(8'b101, 4'd3, 1'b0, 1'b0);
    send("10101", "00101", 2);
    endchk("p101_ov_gap", 5);
    ov = 1'b0;
    ld(8'b101, 4'd3, 1'b0, 1'b0);
    send("10101", "00100", 0);
    endchk("p101_nov", 2);
    ld(8'b101, 4'd3, 1'b0, 1'b0);
    send("10101", "00100", 1);
    endchk("p101_nov_gap", 2);
    ov = 1'b1;
    ld(8'h00, 4'd0, 1'b0, 1'b0);
    send("000000000", "000000000", 0);
    endchk("len0", 8);
    ld(8'b1011_0010, 4'd12, 1'b0, 1'b0);
    send("10110010", "00000001", 0);
    endchk("len12", 8);
    ld(8'b1101, 4'd4, 1'b0, 1'b0);
    send("110", "000", 0);
    ld(8'b1101, 4'd4, 1'b1, 1'b1);
    endchk("load_wvalid", 0);
    send("1", "0", 0);
    endchk("load_wvalid_after", 1);
    ld(8'b0111, 4'd4, 1'b0, 1'b0);
    send("0111011", "0001000", 0);
    endchk("pre_reset", 7);
    #2;
    resetn = 1'b0;
    #1;
    m_fill = 0;
    m_cnt = 0;
    chk("async_reset_match", match, 0);
    chk("async_reset_count", cnt, 0);
    chk("async_reset_progress", prog, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    send("1101", "0001", 0);
    endchk("after_reset", 4);
    ld(8'b1, 4'd1, 1'b0, 1'b0);
    send("11111", "11111", 0);
    endchk("saturate", 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
